// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryption controller.
// One combinational round (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey)
// is reused once per clock. The round key is expanded on the fly alongside the
// data path. Valid/ready handshakes are provided on both the block input side
// and the ciphertext output side.
// Optional feature: define AES_SEQ_ABORT_EN to add an 'abort' input that ends
// an in-flight block without presenting a result.
module aes_round_sequencer #(
  parameter int unsigned NR        = 10,
  parameter logic [7:0]  RCON_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out,
  output logic         busy
`ifdef AES_SEQ_ABORT_EN
  ,
  input  logic         abort
`endif
);

  // The round counter is 4 bits wide, so NR must fit and be non-zero.
  if (NR == 0 || NR > 15) begin : g_nr_check
    $error("aes_round_sequencer: NR must be in 1..15 (got %0d)", NR);
  end

  localparam logic [3:0] NR4 = NR[3:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } fsm_t;

  fsm_t         fsm;
  logic [127:0] state;
  logic [127:0] rkey;
  logic [7:0]   rcon;
  logic [3:0]   rnd;

  logic [127:0] nkey;
  logic [127:0] shifted;
  logic [127:0] nstate;

  // ---------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1
  // ---------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as the multiplicative inverse (a^254, with 0 -> 0)
  // followed by the AES affine transform, instead of a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gmul(gmul(a, a), a);
    x7   = gmul(gmul(x3, x3), a);
    x15  = gmul(gmul(x7, x7), a);
    x31  = gmul(gmul(x15, x15), a);
    x63  = gmul(gmul(x31, x31), a);
    x127 = gmul(gmul(x63, x63), a);
    inv  = gmul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // ---------------------------------------------------------------------
  // Round transforms on a 128-bit block, byte i at [127-8i -: 8];
  // byte i sits at row i%4, column i/4.
  // ---------------------------------------------------------------------
  function automatic logic [127:0] sub_bytes(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = sbox(v[127-8*i -: 8]);
    end
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned w = 0; w < 4; w++) begin
        r[127-8*(w+4*c) -: 8] = v[127-8*(w+4*((c+w)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] v);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = v[127-32*c -: 8];
      a1 = v[119-32*c -: 8];
      a2 = v[111-32*c -: 8];
      a3 = v[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // One AES-128 key-schedule step: four new words from the previous four.
  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] rot, sub, t, n0, n1, n2, n3;
    rot = {k[23:0], k[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t   = sub ^ {rc, 24'h000000};
    n0  = k[127:96] ^ t;
    n1  = k[95:64]  ^ n0;
    n2  = k[63:32]  ^ n1;
    n3  = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Combinational round: next key and next state; the last round skips MixColumns.
  always_comb begin
    nkey    = key_expand(rkey, rcon);
    shifted = shift_rows(sub_bytes(state));
    nstate  = ((rnd == NR4) ? shifted : mix_columns(shifted)) ^ nkey;
  end

  // Control FSM with the round registers and the registered ciphertext output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      state     <= '0;
      rkey      <= '0;
      ct_out    <= '0;
      rnd       <= '0;
      rcon      <= RCON_INIT;
      out_valid <= 1'b0;
    end
`ifdef AES_SEQ_ABORT_EN
    else if (abort && fsm != S_IDLE) begin
      fsm       <= S_IDLE;
      out_valid <= 1'b0;
      ct_out    <= '0;
      rnd       <= '0;
    end
`endif
    else begin
      case (fsm)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            state <= pt_in ^ key_in;
            rkey  <= key_in;
            rcon  <= RCON_INIT;
            rnd   <= 4'd1;
            fsm   <= S_ROUND;
          end
        end
        S_ROUND: begin
          state <= nstate;
          rkey  <= nkey;
          rcon  <= xtime(rcon);
          rnd   <= rnd + 4'd1;
          if (rnd == NR4) begin
            ct_out    <= nstate;
            out_valid <= 1'b1;
            fsm       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  // Status decoded from the FSM register; input is never accepted during reset.
  always_comb begin
    in_ready = rst_n && (fsm == S_IDLE);
    busy     = (fsm != S_IDLE);
  end

endmodule
